// File: rtl/pkg_cl.sv
// Shared definitions for the chess-lab match control (circuito_CL).
// State encodings are also decoded by the debug display logic.
package pkg_cl;

  localparam int COORD_W        = 4;
  localparam int TIMEOUT_PADRAO = 25000;
  localparam int RODADAS_PADRAO = 16;

  typedef enum logic [3:0] {
    OCIOSO     = 4'd0,
    INICIALIZA = 4'd1,
    CARREGA    = 4'd2,
    ESPERA     = 4'd3,
    COMPARA    = 4'd4,
    ACERTO     = 4'd5,
    ERRO       = 4'd6,
    TROCA      = 4'd7,
    FIM        = 4'd15
  } estado_t;

endpackage

// File: rtl/contador_timeout_cl.sv
// Per-move timeout up-counter: clear, enable, terminal-count flag.
// Ports: clock, reset (sync, active-low), clr_i, en_i, fim_o.
module contador_timeout_cl #(
  parameter int MAXIMO = 25000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic fim_o
);

  localparam int W = $clog2(MAXIMO);
  localparam logic [W-1:0] ULTIMO = W'(MAXIMO - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign fim_o = (cnt_q == ULTIMO);

  // Holds at the terminal value so the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !fim_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/controle_rodada_cl.sv
// Round control for a two-player chess-lab match: target fetch,
// move timeout, compare, per-player scores and turn alternation.
// Ports: clock, reset (sync, active-low), iniciar, terminar,
//   temJogada, jogada/alvo coords in; rom_addr, jogador, pontos1/2,
//   acertou, errou, timeout, pronto, db_estado out.
module controle_rodada_cl
  import pkg_cl::*;
#(
  parameter int TIMEOUT_CICLOS = TIMEOUT_PADRAO,
  parameter int N_RODADAS      = RODADAS_PADRAO,
  parameter int ADDR_W         = 4,
  parameter int PONTOS_W       = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic                terminar,
  input  logic                temJogada,
  input  logic [COORD_W-1:0]  jogadaFileira,
  input  logic [COORD_W-1:0]  jogadaColuna,
  input  logic [COORD_W-1:0]  alvoFileira,
  input  logic [COORD_W-1:0]  alvoColuna,
  output logic [ADDR_W-1:0]   rom_addr,
  output logic                jogador,
  output logic [PONTOS_W-1:0] pontos1,
  output logic [PONTOS_W-1:0] pontos2,
  output logic                acertou,
  output logic                errou,
  output logic                timeout,
  output logic                pronto,
  output logic [3:0]          db_estado
);

  localparam logic [ADDR_W-1:0]   ULTIMA = ADDR_W'(N_RODADAS - 1);
  localparam logic [PONTOS_W-1:0] P_MAX  = {PONTOS_W{1'b1}};

  estado_t estado_q, estado_d;

  logic                tj_q;
  logic [ADDR_W-1:0]   rodada_q;
  logic                jogador_q;
  logic [PONTOS_W-1:0] pontos1_q;
  logic [PONTOS_W-1:0] pontos2_q;
  logic                to_q;
  logic [COORD_W-1:0]  alvo_f_q;
  logic [COORD_W-1:0]  alvo_c_q;
  logic [COORD_W-1:0]  jog_f_q;
  logic [COORD_W-1:0]  jog_c_q;

  logic jogada_ev;
  logic aborta;
  logic acerto;
  logic ultima;
  logic to_fim;
  logic to_clr;
  logic to_en;

  assign jogada_ev = temJogada & ~tj_q;
  assign aborta    = terminar &&
                     (estado_q != OCIOSO) &&
                     (estado_q != FIM);
  assign acerto    = (jog_f_q == alvo_f_q) &&
                     (jog_c_q == alvo_c_q);
  assign ultima    = (rodada_q == ULTIMA);
  assign to_clr    = (estado_q == INICIALIZA) ||
                     (estado_q == CARREGA);
  assign to_en     = (estado_q == ESPERA);

  contador_timeout_cl #(
    .MAXIMO(TIMEOUT_CICLOS)
  ) u_timeout (
    .clock(clock),
    .reset(reset),
    .clr_i(to_clr),
    .en_i (to_en),
    .fim_o(to_fim)
  );

  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      OCIOSO:     if (iniciar) estado_d = INICIALIZA;
      INICIALIZA: estado_d = CARREGA;
      CARREGA:    estado_d = ESPERA;
      ESPERA: begin
        // A move in the same cycle as the timeout wins.
        if (jogada_ev)   estado_d = COMPARA;
        else if (to_fim) estado_d = ERRO;
      end
      COMPARA:    estado_d = acerto ? ACERTO : ERRO;
      ACERTO:     estado_d = TROCA;
      ERRO:       estado_d = TROCA;
      TROCA:      estado_d = ultima ? FIM : CARREGA;
      FIM:        if (iniciar) estado_d = INICIALIZA;
      default:    estado_d = OCIOSO;
    endcase
    if (aborta) estado_d = FIM;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q  <= OCIOSO;
      tj_q      <= 1'b0;
      rodada_q  <= '0;
      jogador_q <= 1'b0;
      pontos1_q <= '0;
      pontos2_q <= '0;
      to_q      <= 1'b0;
      alvo_f_q  <= '0;
      alvo_c_q  <= '0;
      jog_f_q   <= '0;
      jog_c_q   <= '0;
    end else begin
      estado_q <= estado_d;
      tj_q     <= temJogada;
      // An aborted state performs none of its register updates.
      if (!aborta) begin
        unique case (estado_q)
          INICIALIZA: begin
            rodada_q  <= '0;
            jogador_q <= 1'b0;
            pontos1_q <= '0;
            pontos2_q <= '0;
          end
          CARREGA: begin
            alvo_f_q <= alvoFileira;
            alvo_c_q <= alvoColuna;
            to_q     <= 1'b0;
          end
          ESPERA: begin
            if (jogada_ev) begin
              jog_f_q <= jogadaFileira;
              jog_c_q <= jogadaColuna;
            end else if (to_fim) begin
              to_q <= 1'b1;
            end
          end
          ACERTO: begin
            if (!jogador_q) begin
              if (pontos1_q != P_MAX) pontos1_q <= pontos1_q + 1'b1;
            end else begin
              if (pontos2_q != P_MAX) pontos2_q <= pontos2_q + 1'b1;
            end
          end
          TROCA: begin
            if (!ultima) begin
              rodada_q  <= rodada_q + 1'b1;
              jogador_q <= ~jogador_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    acertou = 1'b0;
    errou   = 1'b0;
    timeout = 1'b0;
    pronto  = 1'b0;
    unique case (estado_q)
      ACERTO: acertou = 1'b1;
      ERRO: begin
        errou   = 1'b1;
        timeout = to_q;
      end
      FIM:    pronto = 1'b1;
      default: ;
    endcase
  end

  assign rom_addr  = rodada_q;
  assign jogador   = jogador_q;
  assign pontos1   = pontos1_q;
  assign pontos2   = pontos2_q;
  assign db_estado = estado_q;

endmodule

// File: doc/controle_rodada_cl.md
Name: controle_rodada_cl

Overview:
Control unit that sequences a two-player chess-lab match. It drives the target-square ROM address and arms a per-move timeout. It compares the player's row/column against the target, keeps per-player scores and alternates turns. It sits inside circuito_CL, between the input-conditioning logic and the 7-segment/debug outputs.

Parameters:
TIMEOUT_CICLOS, 25000, cycles allowed per move before a timeout error (minimum 4)
N_RODADAS, 16, total moves per match, shared by both players (power of two, at most 2**ADDR_W)
ADDR_W, 4, width of the target-ROM address
PONTOS_W, 4, width of each score counter

Ports:
clock  in  1  system clock; everything updates on the rising edge
reset  in  1  synchronous, active-low reset
iniciar  in  1  level; starts a match from OCIOSO or FIM
terminar  in  1  level; aborts the match to FIM
temJogada  in  1  level; a move is committed on its 0->1 transition
jogadaFileira  in  4  row played
jogadaColuna  in  4  column played
alvoFileira  in  4  target row, combinational ROM data for rom_addr
alvoColuna  in  4  target column, combinational ROM data for rom_addr
rom_addr  out  ADDR_W  target-ROM address = current round index
jogador  out  1  0 = player 1, 1 = player 2
pontos1  out  PONTOS_W  player-1 score
pontos2  out  PONTOS_W  player-2 score
acertou  out  1  one-cycle pulse on a correct move
errou  out  1  one-cycle pulse on a wrong move or timeout
timeout  out  1  one-cycle pulse, coincident with errou, when the move timed out
pronto  out  1  high while in FIM
db_estado  out  4  current state encoding

Behaviour:
- Reset (reset==0 at a rising edge):
  - state = OCIOSO.
  - rom_addr, jogador, pontos1, pontos2, the round counter, the timeout counter and the edge register all clear to 0.
  - acertou, errou, timeout and pronto are 0.
  - Reset overrides all other inputs, mid-match included.
- Edge detect: tj_q <= temJogada every cycle; jogada_ev = temJogada & ~tj_q. Only the first cycle of a held temJogada counts.
- States and db_estado encoding: OCIOSO=0, INICIALIZA=1, CARREGA=2, ESPERA=3, COMPARA=4, ACERTO=5, ERRO=6, TROCA=7, FIM=15.
- OCIOSO: iniciar -> INICIALIZA.
- INICIALIZA (1 cycle): clear scores, the round counter, jogador and the timeout counter -> CARREGA.
- CARREGA (1 cycle):
  - latch alvoFileira/alvoColuna into target registers;
  - clear the timeout counter -> ESPERA.
- ESPERA:
  - the timeout counter increments every cycle;
  - jogada_ev -> latch jogadaFileira/jogadaColuna -> COMPARA;
  - otherwise, when the counter reaches TIMEOUT_CICLOS-1 -> ERRO with the timeout flag set.
  - If jogada_ev and the timeout condition occur in the same cycle, the move wins.
- COMPARA (1 cycle): played row and column both equal the target -> ACERTO; otherwise -> ERRO.
- ACERTO (1 cycle):
  - acertou=1;
  - increment the current player's score, saturating at 2**PONTOS_W-1;
  - -> TROCA.
- ERRO (1 cycle): errou=1; timeout=1 if reached by timeout; no score change; -> TROCA.
- TROCA (1 cycle):
  - if the round counter == N_RODADAS-1 -> FIM;
  - otherwise increment the round counter, toggle jogador, rom_addr = round counter -> CARREGA.
- FIM:
  - pronto=1; scores hold;
  - iniciar -> INICIALIZA, which restarts the match and clears scores.
- terminar=1 in any state other than OCIOSO or FIM -> FIM on the next edge.
  - terminar takes priority over jogada_ev, the timeout condition and every other transition.
  - A score increment in a state that terminar aborts is suppressed.
- Latency: jogada_ev sampled in ESPERA at edge N -> acertou/errou high during cycle N+2 -> ESPERA for the next player at N+5.
- Widths:
  - the timeout counter is $clog2(TIMEOUT_CICLOS) bits;
  - the round counter is ADDR_W bits;
  - no arithmetic wraps except through the explicit comparisons above.

Decomposition:
- Shared package pkg_cl holds:
  - the state typedef and encodings (also used by circuito_CL's debug decoder);
  - the default TIMEOUT_CICLOS and N_RODADAS;
  - the square-coordinate width (4).
- One natural sub-module: contador_timeout_cl, a parameterised up-counter with clear, enable and a terminal-count flag.
- The FSM, score registers and edge detector stay in controle_rodada_cl.

Test Plan:
- Reset, then iniciar for 5 cycles with ROM target (2,2), then jogada (2,2) with temJogada held 2 cycles -> single acertou pulse, pontos1=1, jogador=1, rom_addr=1, no second count.
- Target (3,1), jogada (2,2) -> errou pulse, timeout=0, pontos2 unchanged, jogador returns to 0.
- TIMEOUT_CICLOS=100, no jogada -> errou and timeout pulse together exactly 100 cycles after entering ESPERA, db_estado=6 then 7.
- N_RODADAS=4, all four moves correct -> pontos1=2, pontos2=2, FIM with pronto=1; a further iniciar clears both scores to 0 and db_estado=1.
- terminar asserted in the same cycle as a correct jogada_ev in ESPERA -> FIM next cycle, no acertou, scores unchanged.
- reset=0 for one cycle during ESPERA of round 2 -> next cycle db_estado=0, all outputs 0; a later jogada is ignored until iniciar.
